// File: rtl/pkg_system_mdr.sv
// rtl/pkg_system_mdr.sv - shared types and constants for the MDR unit
//
// DW             : operand width
// data_in_t      : DW-bit operand
// data_t         : 2*DW-bit result / wide datapath word
// op_t           : ALU selector (NULL passes operand a through)
// op_select_t    : requested operation
// mdr_seq_state_t: mdr_sequencer FSM states
package pkg_system_mdr;

  localparam int DW = 16;

  typedef logic [DW-1:0]   data_in_t;
  typedef logic [2*DW-1:0] data_t;

  typedef enum logic [1:0] {
    NULL = 2'd0,
    ADD  = 2'd1,
    SUBS = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    MULT = 2'd0,
    DIV  = 2'd1,
    ROOT = 2'd2
  } op_select_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } mdr_seq_state_t;

endpackage

// File: rtl/mdr_sequencer.sv
// rtl/mdr_sequencer.sv - iterative multiply/divide/root control stage ahead of alu_mult
//
// Optional feature macro: MDR_SEQ_EARLY_TERM_EN (MULT stops once the remaining
// multiplier bits are all zero).
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start, i_op, i_a, i_b request (sampled only in IDLE)
//   o_busy, o_done         status; o_done is a one-cycle pulse
//   o_result, o_rem, o_err result, remainder, divide-by-zero (held until next LOAD)
//   o_alu_*                selector, op, enable, init, flag and operands to the ALU
//   i_alu_M, i_alu_DR      ALU results, captured at the next edge
//   i_alu_flag             ALU flag, only checked by assertion during DIV subtracts
module mdr_sequencer
  import pkg_system_mdr::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  op_select_t i_op,
  input  data_in_t   i_a,
  input  data_in_t   i_b,
  output logic       o_busy,
  output logic       o_done,
  output data_t      o_result,
  output data_in_t   o_rem,
  output logic       o_err,
  output op_t        o_alu_sltr,
  output op_select_t o_alu_op,
  output logic       o_alu_en,
  output logic       o_alu_init,
  output logic       o_alu_flag,
  output data_in_t   o_alu_a_M,
  output data_in_t   o_alu_b_M,
  output data_t      o_alu_a_DR,
  output data_t      o_alu_b_DR,
  input  data_in_t   i_alu_M,
  input  data_t      i_alu_DR,
  input  logic       i_alu_flag
);

  localparam int CNT_W = $clog2(DW + 1);

  mdr_seq_state_t   state_q, state_d;
  op_select_t       op_q, op_d;
  data_in_t         a_q, a_d;           // multiplier/acc_lo, dividend or radicand shifter
  data_in_t         b_q, b_d;           // multiplicand or divisor
  data_in_t         acc_hi_q, acc_hi_d; // MULT upper accumulator
  data_t            rem_q, rem_d;       // DIV/ROOT partial remainder
  data_in_t         qr_q, qr_d;         // quotient or root being built
  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_t            result_q, result_d;
  data_in_t         rem_out_q, rem_out_d;
  logic             err_q, err_d;

  logic             carry;
  data_t            rem_p;
  data_t            trial;
`ifdef MDR_SEQ_EARLY_TERM_EN
  data_t            mul_mask;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_hi_d   = acc_hi_q;
    rem_d      = rem_q;
    qr_d       = qr_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    rem_out_d  = rem_out_q;
    err_d      = err_q;
    carry      = 1'b0;
    rem_p      = '0;
    trial      = '0;
`ifdef MDR_SEQ_EARLY_TERM_EN
    mul_mask   = (data_t'(1) << cnt_q) - data_t'(1);
`endif
    o_alu_sltr = NULL;
    o_alu_op   = MULT;
    o_alu_en   = 1'b0;
    o_alu_init = 1'b0;
    o_alu_flag = 1'b0;
    o_alu_a_M  = '0;
    o_alu_b_M  = '0;
    o_alu_a_DR = '0;
    o_alu_b_DR = '0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          op_d    = i_op;
          a_d     = i_a;
          b_d     = i_b;
          state_d = LOAD;
        end
      end

      LOAD: begin
        o_alu_init = 1'b1;
        acc_hi_d   = '0;
        rem_d      = '0;
        qr_d       = '0;
        err_d      = 1'b0;
        result_d   = '0;
        rem_out_d  = '0;
        cnt_d      = (op_q == ROOT) ? CNT_W'(DW / 2) : CNT_W'(DW);
        state_d    = ITER;
`ifdef MDR_SEQ_EARLY_TERM_EN
        // Shift b through acc_lo so early exit tracks the highest set bit of b.
        if (op_q == MULT) begin
          a_d = b_q;
          b_d = a_q;
        end
`endif
        // Divide-by-zero settles its result here and passes through one
        // idle ITER cycle, which keeps its done pulse after edge 2.
        if (op_q == DIV && b_q == '0) begin
          err_d     = 1'b1;
          result_d  = {{DW{1'b0}}, {DW{1'b1}}};
          rem_out_d = a_q;
        end
      end

      ITER: begin
        o_alu_en = 1'b1;
        o_alu_op = op_q;
        cnt_d    = cnt_q - 1'b1;
        if (err_q) begin
          state_d = DONE;
        end else begin
          if (cnt_q == CNT_W'(1)) state_d = DONE;
          case (op_q)
            MULT: begin
              o_alu_a_M = acc_hi_q;
              o_alu_b_M = b_q;
              if (a_q[0]) o_alu_sltr = ADD;
              // The ALU sum is DW bits wide; a wrap shows up as a smaller value.
              carry    = (i_alu_M < acc_hi_q);
              acc_hi_d = {carry, i_alu_M[DW-1:1]};
              a_d      = {i_alu_M[0], a_q[DW-1:1]};
`ifdef MDR_SEQ_EARLY_TERM_EN
              if ((data_t'(a_q) & mul_mask) == '0) begin
                {acc_hi_d, a_d} = {acc_hi_q, a_q} >> cnt_q;
                state_d         = DONE;
              end
`endif
            end
            DIV: begin
              rem_p      = {rem_q[2*DW-2:0], a_q[DW-1]};
              a_d        = a_q << 1;
              o_alu_a_DR = rem_p;
              if (rem_p >= data_t'(b_q)) begin
                o_alu_sltr = SUBS;
                o_alu_b_DR = data_t'(b_q);
                o_alu_flag = 1'b1;
                qr_d       = {qr_q[DW-2:0], 1'b1};
              end else begin
                qr_d       = {qr_q[DW-2:0], 1'b0};
              end
              rem_d = i_alu_DR;
            end
            ROOT: begin
              rem_p      = {rem_q[2*DW-3:0], a_q[DW-1:DW-2]};
              trial      = {{(DW-2){1'b0}}, qr_q, 2'b01};
              a_d        = a_q << 2;
              o_alu_a_DR = rem_p;
              if (rem_p >= trial) begin
                o_alu_sltr = SUBS;
                o_alu_b_DR = trial;
                qr_d       = {qr_q[DW-2:0], 1'b1};
              end else begin
                qr_d       = {qr_q[DW-2:0], 1'b0};
              end
              rem_d = i_alu_DR;
            end
            default: ;
          endcase
          if (state_d == DONE) begin
            result_d  = (op_q == MULT) ? {acc_hi_d, a_d} : data_t'(qr_d);
            rem_out_d = (op_q == MULT) ? '0 : rem_d[DW-1:0];
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      op_q      <= MULT;
      a_q       <= '0;
      b_q       <= '0;
      acc_hi_q  <= '0;
      rem_q     <= '0;
      qr_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      rem_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_hi_q  <= acc_hi_d;
      rem_q     <= rem_d;
      qr_q      <= qr_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      rem_out_q <= rem_out_d;
      err_q     <= err_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_result = result_q;
  assign o_rem    = rem_out_q;
  assign o_err    = err_q;

  // A divide subtract is only issued when rem' >= b, so the ALU must report no borrow.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == ITER && op_q == DIV && o_alu_sltr == SUBS) |-> i_alu_flag);

endmodule
